// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its pipeline registers.
package fetch_stage_pkg;

  localparam int unsigned WORD = 32;

  // Word loaded into a pipeline register when it is flushed.
  localparam logic [WORD-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StWait  = 2'b01,
    StFault = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register with load-enable, flush and bubble controls.
// Flush clears everything; a bubble only drops valid and keeps the old payload.
module ifid_register
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic            bubble,
  input  logic [WORD-1:0] instr_in,
  input  logic [WORD-1:0] pc_in,
  output logic [WORD-1:0] instr,
  output logic [WORD-1:0] pc,
  output logic            valid
);

  logic [WORD-1:0] instr_q, instr_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  // Next contents: flush beats load; a bubble only clears valid.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_WORD;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (load) begin
      if (bubble) begin
        valid_d = 1'b0;
      end else begin
        instr_d = instr_in;
        pc_d    = pc_in;
        valid_d = 1'b1;
      end
    end
  end

  // Register state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, fills IF/ID and
// traps into a sticky fault state when memory stays not-ready for too long.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic [WORD-1:0] imem_addr,
  input  logic [WORD-1:0] imem_rdata,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [WORD-1:0] branch_target,
  output logic [WORD-1:0] pc_next,
  output logic [WORD-1:0] ifid_instr,
  output logic [WORD-1:0] ifid_pc,
  output logic            ifid_valid,
  output logic            fetch_fault
);

  localparam logic [WORD-1:0] PcIncW   = WORD'(PC_INC);
  localparam logic [7:0]      MaxWaitW = 8'(MAX_WAIT);

  fetch_state_e    state_q, state_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic [7:0]      wait_cnt_inc;
  logic [WORD-1:0] pc_q, pc_d;
  logic            active;
  logic            flush;
  logic            load;

  assign wait_cnt_inc = wait_cnt_q + 8'd1;

  // Memory-facing outputs depend only on the PC register.
  assign imem_addr = pc_q;
  assign pc_next   = pc_q + PcIncW;

  // State, wait counter and PC registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pc_q       <= pc_d;
    end
  end

  // Next state and wait counter: branch > stall > imem_ready; FAULT is terminal.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StFetch, StWait: begin
        if (branch_taken) begin
          state_d    = StFetch;
          wait_cnt_d = '0;
        end else if (stall) begin
          state_d    = state_q;
        end else if (imem_ready) begin
          state_d    = StFetch;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          state_d    = (wait_cnt_inc == MaxWaitW) ? StFault : StWait;
        end
      end
      StFault: state_d = StFault;
      default: begin
        state_d    = StFetch;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Control outputs and next PC; redirect targets are forced word aligned.
  always_comb begin
    active      = (state_q != StFault);
    fetch_fault = (state_q == StFault);
    flush       = active && branch_taken;
    load        = active && !stall;
    pc_d        = pc_q;
    if (flush) begin
      pc_d = {branch_target[WORD-1:2], 2'b00};
    end else if (load && imem_ready) begin
      pc_d = pc_next;
    end
  end

  ifid_register u_ifid (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (load),
    .flush    (flush),
    .bubble   (!imem_ready),
    .instr_in (imem_rdata),
    .pc_in    (pc_next),
    .instr    (ifid_instr),
    .pc       (ifid_pc),
    .valid    (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID words into a queue,
// a monitor pops and compares whenever a fetched word is presented.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc_next;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        fetch_fault;

  int checks = 0;
  int failures = 0;
  logic        in_fault = 1'b0;
  logic [63:0] exp_q[$];

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_INC   (4),
    .MAX_WAIT (8)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_next       (pc_next),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid),
    .fetch_fault   (fetch_fault)
  );

  always #5 CLK = ~CLK;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One cycle: check PC-side outputs at the negedge, then drive inputs for the next posedge.
  task automatic step(input logic [31:0] exp_addr, input logic exp_valid, input logic rdy,
                      input logic [31:0] rdata, input logic stl, input logic br,
                      input logic [31:0] tgt);
    logic [31:0] exp_next;
    @(negedge CLK);
    exp_next = exp_addr + 32'd4;
    check32("imem_addr", imem_addr, exp_addr);
    check32("pc_next", pc_next, exp_next);
    check32("ifid_valid", {31'd0, ifid_valid}, {31'd0, exp_valid});
    imem_ready    = rdy;
    imem_rdata    = rdata;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    if (rdy && !stl && !br && !in_fault) exp_q.push_back({rdata, exp_next});
  endtask

  // Monitor: a word presented right after a non-stalled edge is a new IF/ID load.
  initial begin : monitor
    logic        ld;
    logic [63:0] exp;
    forever begin
      @(posedge CLK);
      ld = RST_N && !stall;
      #1;
      if (ifid_valid && ld) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_unexpected: got instr=%08h pc=%08h expected none",
                   ifid_instr, ifid_pc);
        end else begin
          exp = exp_q.pop_front();
          if ({ifid_instr, ifid_pc} !== exp) begin
            failures++;
            $display("FAIL ifid_word: got instr=%08h pc=%08h expected instr=%08h pc=%08h",
                     ifid_instr, ifid_pc, exp[63:32], exp[31:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    #3;
    check32("rst_addr", imem_addr, 32'h0);
    check32("rst_pc_next", pc_next, 32'h4);
    check32("rst_ifid_instr", ifid_instr, 32'h0);
    check32("rst_ifid_pc", ifid_pc, 32'h0);
    check32("rst_valid_fault", {30'd0, ifid_valid, fetch_fault}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Sequential fetch.
    step(32'h0, 0, 1, 32'hE081_0002, 0, 0, 0);
    step(32'h4, 1, 1, 32'hE243_3001, 0, 0, 0);
    // Stall at PC=8 for two cycles; ready words offered meanwhile must be ignored.
    step(32'h8, 1, 1, 32'hBAD0_0001, 1, 0, 0);
    check32("stall_ifid_pc", ifid_pc, 32'h8);
    step(32'h8, 1, 1, 32'hBAD0_0002, 1, 0, 0);
    check32("stall_ifid_instr", ifid_instr, 32'hE243_3001);
    check32("stall_ifid_pc2", ifid_pc, 32'h8);
    step(32'h8, 1, 1, 32'hE1A0_0000, 0, 0, 0);
    // Branch with simultaneous stall and ready at PC=12.
    step(32'hC, 1, 1, 32'hDEAD_BEEF, 1, 1, 32'h40);
    step(32'h40, 0, 1, 32'h1111_1111, 0, 0, 0);
    check32("flush_ifid_pc", ifid_pc, 32'h0);
    // Three wait cycles, then the word latches.
    step(32'h44, 1, 0, 32'h0, 0, 0, 0);
    step(32'h44, 0, 0, 32'h0, 0, 0, 0);
    step(32'h44, 0, 0, 32'h0, 0, 0, 0);
    step(32'h44, 0, 1, 32'h2222_2222, 0, 0, 0);
    step(32'h48, 1, 1, 32'h3333_3333, 0, 0, 0);
    check32("short_wait_fault", {31'd0, fetch_fault}, 32'h0);
    // Eight wait cycles raise the fault.
    step(32'h4C, 1, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(32'h4C, 0, 0, 32'h0, 0, 0, 0);
    check32("pre_fault", {31'd0, fetch_fault}, 32'h0);
    in_fault = 1'b1;
    step(32'h4C, 0, 1, 32'h5555_5555, 0, 1, 32'h80);
    check32("fault_set", {31'd0, fetch_fault}, 32'h1);
    step(32'h4C, 0, 1, 32'h6666_6666, 0, 0, 0);
    check32("fault_sticky", {31'd0, fetch_fault}, 32'h1);
    check32("fault_ifid_pc", ifid_pc, 32'h4C);
    check32("fault_ifid_instr", ifid_instr, 32'h3333_3333);
    // Asynchronous reset mid-cycle.
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    imem_ready = 1'b0;
    branch_taken = 1'b0;
    in_fault = 1'b0;
    #1;
    check32("arst_addr", imem_addr, 32'h0);
    check32("arst_ifid", ifid_instr | ifid_pc, 32'h0);
    check32("arst_valid_fault", {30'd0, ifid_valid, fetch_fault}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    // Unaligned redirect to the top word, then wrap.
    step(32'h0, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFF);
    step(32'hFFFF_FFFC, 0, 1, 32'h4444_4444, 0, 0, 0);
    step(32'h0, 1, 0, 32'h0, 0, 0, 0);
    check32("wrap_ifid_pc", ifid_pc, 32'h0);
    step(32'h0, 0, 0, 32'h0, 0, 0, 0);
    @(negedge CLK);
    check32("scoreboard_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined datapath; sits directly upstream of the register file and decode.
- Owns the program counter and drives the fetch address to instruction memory.
- Latches fetched words into the IF/ID pipeline register and supplies the incremented PC that the register file loads into R15 through its PCin port.
- Handles stall (from the hazard unit), branch redirect/flush, memory wait states and a wait-timeout fault.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- PC_INC, 4, byte increment per sequential fetch.
- MAX_WAIT, 8, consecutive not-ready cycles before fetch_fault is raised (1..255).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST_N  input  1  asynchronous, active-low reset.
- imem_addr  output  32  fetch address; always equals the current PC.
- imem_rdata  input  32  instruction word from instruction memory.
- imem_ready  input  1  imem_rdata is valid for imem_addr this cycle.
- stall  input  1  hazard unit holds PC and IF/ID (load-enable low).
- branch_taken  input  1  redirect request from a later stage.
- branch_target  input  32  redirect address, byte address, word aligned.
- pc_next  output  32  PC + PC_INC, combinational; feeds register file PCin.
- ifid_instr  output  32  latched instruction.
- ifid_pc  output  32  PC + PC_INC of the latched instruction.
- ifid_valid  output  1  IF/ID holds a real instruction, not a bubble.
- fetch_fault  output  1  sticky; memory exceeded MAX_WAIT.

Behaviour:
- Reset (async, RST_N=0):
  - PC=RESET_PC, so imem_addr=RESET_PC and pc_next=RESET_PC+PC_INC.
  - ifid_instr=0, ifid_pc=0, ifid_valid=0, fetch_fault=0.
  - wait_cnt=0, state=FETCH.
  - Reset mid-wait or mid-redirect discards everything; the first fetch after release is RESET_PC.
- States: FETCH, WAIT, FAULT.
- Per-cycle priority: reset > branch_taken > stall > imem_ready.
- branch_taken=1, any state except FAULT:
  - Next PC=branch_target.
  - IF/ID is flushed: ifid_valid=0, ifid_instr=0, ifid_pc=0.
  - wait_cnt=0, state=FETCH.
  - Overrides a simultaneous stall. The word returned in the same cycle is discarded.
- stall=1 and no branch: PC, IF/ID and wait_cnt all hold; state holds.
- FETCH or WAIT, no stall, no branch, imem_ready=1:
  - IF/ID loads ifid_instr=imem_rdata, ifid_pc=PC+PC_INC, ifid_valid=1.
  - PC=PC+PC_INC, wait_cnt=0, state=FETCH.
  - One-cycle latency from ready to IF/ID.
- FETCH or WAIT, no stall, no branch, imem_ready=0:
  - IF/ID loads a bubble (ifid_valid=0; instr and pc hold their old values). PC holds.
  - wait_cnt increments; state=WAIT.
  - When wait_cnt reaches MAX_WAIT: state=FAULT, fetch_fault=1.
- FAULT:
  - PC and IF/ID frozen, ifid_valid=0.
  - All inputs ignored, including branch_taken.
  - Exit only via reset.
- Arithmetic: PC+PC_INC is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). No fault on wrap.
- Alignment: branch_target bits [1:0] are forced to 0 when loaded.
- imem_addr and pc_next are combinational from the PC register only, never from inputs.

Decomposition:
- Shared package holds:
  - state encoding FETCH=2'b00, WAIT=2'b01, FAULT=2'b10;
  - the NOP/bubble word constant 32'h0;
  - the width constant WORD=32.
- One natural sub-module: ifid_register. It is the IF/ID pipeline register with load, flush and bubble controls, and is reused as the template for later pipeline registers.
- The PC register and FSM stay in fetch_stage.

Test Plan:
- Reset then imem_ready=1 for 3 cycles, rdata 0xE0810002/0xE2433001/0xE1A00000:
  - imem_addr goes 0→4→8→12.
  - ifid_pc goes 4,8,12 with matching instructions; ifid_valid=1 from cycle 1.
  - pc_next is always imem_addr+4.
- Running at PC=8, stall=1 for 2 cycles:
  - PC stays 8 and IF/ID is unchanged.
  - After release, fetch resumes at 8 with no duplicate or lost word.
- At PC=12, branch_taken=1 with branch_target=0x40, stall=1 and imem_ready=1 all in the same cycle:
  - Next cycle imem_addr=0x40 and ifid_valid=0.
  - The cycle after, ifid_pc=0x44.
- imem_ready=0 for 3 cycles, then 1 (MAX_WAIT=8):
  - Three bubbles (ifid_valid=0) and PC held.
  - The word then latches; fetch_fault stays 0.
- imem_ready=0 for 8 cycles:
  - fetch_fault=1 after the 8th cycle.
  - A later branch_taken is ignored.
  - RST_N pulsed low asynchronously mid-cycle: all outputs return to reset values immediately and PC=RESET_PC.
- PC preset via branch to 0xFFFF_FFFC, imem_ready=1:
  - The next imem_addr is 0x0000_0000.
  - ifid_pc of that fetch is 0x0000_0000.
